// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing the read port of an async FIFO among NUM_REQ consumers.
// Grants bursts of up to BURST_LEN pops and steers popped data with per-consumer valid strobes.
//
//   state | meaning
//   IDLE  | no owner; pick next requester when FIFO has data
//   BURST | owner popping; stalls while REMPTY, ends on last pop or release
//   GAP   | one dead cycle so the final RD_VALID never overlaps a new grant
module fifo_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_REQ-1:0]    REQ,
    input  logic                  REMPTY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic                  R_INC,
    output logic [NUM_REQ-1:0]    GNT,
    output logic [NUM_REQ-1:0]    RD_VALID,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  BUSY
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
    localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]         state;
    logic [LW-1:0]      last;
    logic [LW-1:0]      winner;
    logic [NUM_REQ-1:0] winner_oh;
    logic [CW-1:0]      count;
    logic               owner_req;

    // Search starts just after the previous winner so every requester gets a turn.
    function automatic logic [LW-1:0] pick(input logic [NUM_REQ-1:0] req,
                                           input logic [LW-1:0] lst);
        logic [LW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(lst) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                w     = LW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        winner    = pick(REQ, last);
        winner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
        owner_req = |(GNT & REQ);
        R_INC     = (state == BURST) && owner_req && !REMPTY;
        BUSY      = (state != IDLE);
        RD_DATA   = RDATA;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            GNT      <= '0;
            RD_VALID <= '0;
            count    <= '0;
            last     <= LAST_RST;
        end else begin
            RD_VALID <= R_INC ? GNT : '0;
            case (state)
                IDLE: begin
                    if (|REQ && !REMPTY) begin
                        state <= BURST;
                        GNT   <= winner_oh;
                        last  <= winner;
                        count <= '0;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        state <= GAP;
                        GNT   <= '0;
                    end else if (R_INC) begin
                        count <= count + CW'(1);
                        if (count == LAST_CNT) begin
                            state <= GAP;
                            GNT   <= '0;
                        end
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
    a_rv_onehot:  assert property (@(posedge CLK) disable iff (RST) $onehot0(RD_VALID));
    a_no_pop_empty: assert property (@(posedge CLK) disable iff (RST) !(R_INC && REMPTY));
    a_burst_len:  assert property (@(posedge CLK) disable iff (RST) count <= CW'(BURST_LEN));
`endif

endmodule
